// File: rtl/vec_sequencer.sv
// vec_sequencer: burst controller for the vector regfile, ALU and data memory.
// cmd_* in, done/err out, reg/alu/mem controls out; VEC_SEQ_WIDE_RESULT_EN adds the EX_WHI write.
module vec_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 512,
  parameter int ADDR_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [1:0]         cmd_rd,
  input  logic [1:0]         cmd_rs1,
  input  logic [1:0]         cmd_rs2,
  input  logic [1:0]         cmd_alu_op,
  input  logic [ADDR_W-1:0]  cmd_addr,
  output logic               done,
  output logic               err,
  output logic               reg_write_enable,
  output logic [1:0]         reg_address1,
  output logic [1:0]         reg_address2,
  output logic [REG_W-1:0]   reg_data_in,
  input  logic [REG_W-1:0]   reg_data_out1,
  output logic [1:0]         alu_op,
  input  logic [2*REG_W-1:0] alu_result,
  output logic               mem_write_enable,
  output logic               mem_read_enable,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_data_in,
  input  logic [DATA_W-1:0]  mem_data_out
);
  localparam int WORDS = REG_W / DATA_W;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LD_RD   = 4'd1;
  localparam logic [3:0] LD_WAIT = 4'd2;
  localparam logic [3:0] LD_WR   = 4'd3;
  localparam logic [3:0] ST      = 4'd4;
  localparam logic [3:0] EX_CAP  = 4'd5;
  localparam logic [3:0] EX_WLO  = 4'd6;
`ifdef VEC_SEQ_WIDE_RESULT_EN
  localparam logic [3:0] EX_WHI  = 4'd7;
`endif
  localparam logic [3:0] DONE    = 4'd8;

  logic [3:0]        state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cidx;
  logic [1:0]        rd;
  logic [1:0]        rs1;
  logic [1:0]        rs2;
  logic [1:0]        aop;
  logic [ADDR_W-1:0] base;
  logic              bad;
  logic [REG_W-1:0]  buffer;
  logic [31:0]       rd_off;
  logic [31:0]       cap_off;
`ifdef VEC_SEQ_WIDE_RESULT_EN
  logic [REG_W-1:0]  upper;
`else
  logic              unused_upper;
  assign unused_upper = ^alu_result[2*REG_W-1:REG_W];
`endif

  // Read data lags the address by one cycle, so the word landing
  // now belongs to the previous count; in LD_WAIT cnt has wrapped
  // to 0, which makes this the last word.
  assign cidx    = cnt - CW'(1);
  assign rd_off  = 32'(cnt) * DATA_W;
  assign cap_off = 32'(cidx) * DATA_W;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rd     <= '0;
      rs1    <= '0;
      rs2    <= '0;
      aop    <= '0;
      base   <= '0;
      bad    <= 1'b0;
      buffer <= '0;
`ifdef VEC_SEQ_WIDE_RESULT_EN
      upper  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rd   <= cmd_rd;
            rs1  <= cmd_rs1;
            rs2  <= cmd_rs2;
            aop  <= cmd_alu_op;
            base <= cmd_addr;
            cnt  <= '0;
            bad  <= (cmd_op == 2'b11);
            case (cmd_op)
              2'b00:   state <= LD_RD;
              2'b01:   state <= ST;
              2'b10:   state <= EX_CAP;
              default: state <= DONE;
            endcase
          end
        end
        LD_RD: begin
          if (cnt != '0)
            buffer[cap_off +: DATA_W] <= mem_data_out;
          cnt <= cnt + CW'(1);
          if (cnt == LAST)
            state <= LD_WAIT;
        end
        LD_WAIT: begin
          buffer[cap_off +: DATA_W] <= mem_data_out;
          state <= LD_WR;
        end
        LD_WR: state <= DONE;
        ST: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST)
            state <= DONE;
        end
        EX_CAP: begin
          buffer <= alu_result[REG_W-1:0];
`ifdef VEC_SEQ_WIDE_RESULT_EN
          upper  <= alu_result[2*REG_W-1:REG_W];
`endif
          state  <= EX_WLO;
        end
        EX_WLO: begin
`ifdef VEC_SEQ_WIDE_RESULT_EN
          state <= EX_WHI;
`else
          state <= DONE;
`endif
        end
`ifdef VEC_SEQ_WIDE_RESULT_EN
        EX_WHI: state <= DONE;
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready        = (state == IDLE);
    done             = (state == DONE);
    err              = done & bad;
    reg_write_enable = 1'b0;
    reg_address1     = '0;
    reg_address2     = '0;
    reg_data_in      = '0;
    alu_op           = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    case (state)
      LD_RD: begin
        mem_read_enable = 1'b1;
        mem_address     = base + ADDR_W'(cnt);
      end
      LD_WR: begin
        reg_write_enable = 1'b1;
        reg_address1     = rd;
        reg_data_in      = buffer;
      end
      ST: begin
        reg_address1     = rd;
        mem_write_enable = 1'b1;
        mem_address      = base + ADDR_W'(cnt);
        mem_data_in      = reg_data_out1[rd_off +: DATA_W];
      end
      EX_CAP: begin
        reg_address1 = rs1;
        reg_address2 = rs2;
        alu_op       = aop;
      end
      EX_WLO: begin
        reg_write_enable = 1'b1;
        reg_address1     = rd;
        reg_data_in      = buffer;
      end
`ifdef VEC_SEQ_WIDE_RESULT_EN
      EX_WHI: begin
        reg_write_enable = 1'b1;
        reg_address1     = rd + 2'd1;
        reg_data_in      = upper;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_vec_sequencer.sv
// tb_vec_sequencer: table-driven bench with behavioural regfile, ALU and memory.
// Memory accesses are scoreboarded against a queue filled when each command is issued.
module tb_vec_sequencer;
  localparam int DATA_W = 32;
  localparam int REG_W  = 512;
  localparam int ADDR_W = 9;
`ifdef VEC_SEQ_WIDE_RESULT_EN
  localparam int LAT_EX = 4;
  localparam bit WIDE   = 1'b1;
`else
  localparam int LAT_EX = 3;
  localparam bit WIDE   = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [1:0]         cmd_rd;
  logic [1:0]         cmd_rs1;
  logic [1:0]         cmd_rs2;
  logic [1:0]         cmd_alu_op;
  logic [ADDR_W-1:0]  cmd_addr;
  logic               done;
  logic               err;
  logic               reg_write_enable;
  logic [1:0]         reg_address1;
  logic [1:0]         reg_address2;
  logic [REG_W-1:0]   reg_data_in;
  logic [REG_W-1:0]   reg_data_out1;
  logic [1:0]         alu_op;
  logic [2*REG_W-1:0] alu_result;
  logic               mem_write_enable;
  logic               mem_read_enable;
  logic [ADDR_W-1:0]  mem_address;
  logic [DATA_W-1:0]  mem_data_in;
  logic [DATA_W-1:0]  mem_data_out;

  vec_sequencer #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_alu_op(cmd_alu_op), .cmd_addr(cmd_addr),
    .done(done), .err(err),
    .reg_write_enable(reg_write_enable),
    .reg_address1(reg_address1), .reg_address2(reg_address2),
    .reg_data_in(reg_data_in), .reg_data_out1(reg_data_out1),
    .alu_op(alu_op), .alu_result(alu_result),
    .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1023:0] alu(input logic [511:0] a,
                                        input logic [511:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return {512'd0, a} + {512'd0, b};
      2'd1:    return {512'd0, a} - {512'd0, b};
      2'd2:    return {512'd0, a & b};
      default: return {a ^ b, a | b};
    endcase
  endfunction

  function automatic logic [511:0] rf_init(input int i);
    case (i)
      0:       return '1;
      1:       return 512'd1;
      2:       return '0;
      default: return {16{32'hDEAD_BEEF}};
    endcase
  endfunction

  function automatic logic [31:0] mem_init(input int a);
    if (a >= 16 && a < 32) return 32'(a - 15);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // behavioural datapath
  logic [511:0] rf [4];
  logic [31:0]  mem [512];
  bit           preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4; i++) rf[i] <= rf_init(i);
      for (int i = 0; i < 512; i++) mem[i] <= mem_init(i);
      mem_data_out <= '0;
    end else begin
      if (reg_write_enable) rf[reg_address1] <= reg_data_in;
      if (mem_write_enable) mem[mem_address] <= mem_data_in;
      if (mem_read_enable) mem_data_out <= mem[mem_address];
    end
  end

  assign reg_data_out1 = rf[reg_address1];
  assign alu_result = alu(rf[reg_address1], rf[reg_address2], alu_op);

  // expected architectural state
  logic [511:0] exp_rf [4];
  logic [31:0]  exp_mem [512];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0]  addr;
    bit          we;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [1:0] aop;
    logic [8:0] addr;
    int         lat;
    bit         er;
  } vec_t;

  typedef struct {
    int lat;
    bit er;
  } sb_t;

  acc_t aq [$];
  sb_t  sbq [$];
  acc_t mon_a;
  int   act_cnt = 0;
  logic any_out;

  assign any_out = |{reg_write_enable, reg_address1, reg_address2,
                     reg_data_in, alu_op, mem_write_enable,
                     mem_read_enable, mem_address, mem_data_in};

  always @(negedge clk) begin
    if (reset && !preload) begin
      if (reg_write_enable | mem_write_enable | mem_read_enable)
        act_cnt++;
      if (cmd_ready | done)
        chk("idle_outputs_zero", any_out, 0);
      if (mem_read_enable | mem_write_enable) begin
        if (aq.size() == 0) begin
          chk("unexpected_mem_access", mem_address, 512'h1FF_DEAD);
        end else begin
          mon_a = aq.pop_front();
          chk("mem_addr", mem_address, mon_a.addr);
          chk("mem_we", mem_write_enable, mon_a.we);
          if (mon_a.we) chk("mem_wdata", mem_data_in, mon_a.data);
        end
      end
    end
  end

  task automatic model_issue(input vec_t v, input bit upd);
    logic [1023:0] r;
    acc_t a;
    case (v.op)
      2'b00: for (int i = 0; i < 16; i++) begin
        a.addr = v.addr + 9'(i);
        a.we   = 1'b0;
        a.data = '0;
        aq.push_back(a);
        if (upd) exp_rf[v.rd][32*i +: 32] = exp_mem[a.addr];
      end
      2'b01: for (int i = 0; i < 16; i++) begin
        a.addr = v.addr + 9'(i);
        a.we   = 1'b1;
        a.data = exp_rf[v.rd][32*i +: 32];
        aq.push_back(a);
        if (upd) exp_mem[a.addr] = a.data;
      end
      2'b10: begin
        r = alu(exp_rf[v.rs1], exp_rf[v.rs2], v.aop);
        if (upd) begin
          exp_rf[v.rd] = r[511:0];
          if (WIDE) exp_rf[v.rd + 2'd1] = r[1023:512];
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive(input vec_t v);
    cmd_op     = v.op;
    cmd_rd     = v.rd;
    cmd_rs1    = v.rs1;
    cmd_rs2    = v.rs2;
    cmd_alu_op = v.aop;
    cmd_addr   = v.addr;
    cmd_valid  = 1'b1;
  endtask

  task automatic chk_state();
    int d;
    for (int i = 0; i < 4; i++)
      chk($sformatf("reg%0d", i), rf[i], exp_rf[i]);
    d = 0;
    for (int a = 0; a < 512; a++)
      if (mem[a] !== exp_mem[a]) d++;
    chk("mem_image_diffs", d, 0);
  endtask

  task automatic run_cmd(input vec_t v);
    int  n;
    bit  got;
    sb_t e;
    @(negedge clk);
    drive(v);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    @(posedge clk);
    sbq.push_back('{v.lat, v.er});
    model_issue(v, 1'b1);
    #1 cmd_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    e = sbq.pop_front();
    if (!got) begin
      chk("done_timeout", n, e.lat);
    end else begin
      chk("done_latency", n, e.lat);
      chk("err_flag", err, e.er);
      chk("ready_in_done", cmd_ready, 0);
    end
    @(negedge clk);
    chk("ready_after_done", cmd_ready, 1);
    chk("done_one_cycle", done, 0);
    chk_state();
  endtask

  // command held valid across its own burst: accepted again only
  // on the IDLE edge that follows done
  task automatic held_seq(input vec_t v);
    int  lt;
    int  a0;
    bit  dn;
    lt = v.lat;
    @(negedge clk);
    a0 = act_cnt;
    drive(v);
    model_issue(v, 1'b1);
    model_issue(v, 1'b1);
    for (int n = 1; n <= 2*lt + 3; n++) begin
      @(negedge clk);
      dn = (n == lt) || (n == 2*lt + 1);
      chk("held_done", done, dn);
      chk("held_err", err, dn && v.er);
      chk("held_ready", cmd_ready, (n == lt + 1) || (n >= 2*lt + 2));
      if (n == 2*lt + 1) cmd_valid = 1'b0;
    end
    if (v.op == 2'b11) chk("illegal_activity", act_cnt - a0, 0);
    chk_state();
  endtask

  vec_t vt [9];
  vec_t ab;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    preload = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_rd = '0;
    cmd_rs1 = '0;
    cmd_rs2 = '0;
    cmd_alu_op = '0;
    cmd_addr = '0;
    //        op     rd    rs1   rs2   aop   addr    lat     err
    vt[0] = '{2'b00, 2'd2, 2'd0, 2'd0, 2'd0, 9'h010, 19,     1'b0};
    vt[1] = '{2'b01, 2'd2, 2'd0, 2'd0, 2'd0, 9'h1F8, 17,     1'b0};
    vt[2] = '{2'b10, 2'd3, 2'd0, 2'd1, 2'd0, 9'h000, LAT_EX, 1'b0};
    vt[3] = '{2'b11, 2'd1, 2'd2, 2'd3, 2'd1, 9'h055, 1,      1'b1};
    vt[4] = '{2'b00, 2'd1, 2'd0, 2'd0, 2'd0, 9'h1FA, 19,     1'b0};
    vt[5] = '{2'b10, 2'd0, 2'd2, 2'd1, 2'd1, 9'h000, LAT_EX, 1'b0};
    vt[6] = '{2'b01, 2'd0, 2'd0, 2'd0, 2'd0, 9'h100, 17,     1'b0};
    vt[7] = '{2'b10, 2'd1, 2'd1, 2'd2, 2'd3, 9'h000, LAT_EX, 1'b0};
    vt[8] = '{2'b01, 2'd2, 2'd0, 2'd0, 2'd0, 9'h000, 17,     1'b0};
    for (int i = 0; i < 4; i++) exp_rf[i] = rf_init(i);
    for (int a = 0; a < 512; a++) exp_mem[a] = mem_init(a);
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_outputs", any_out, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);

    for (int k = 0; k < 9; k++) run_cmd(vt[k]);

    held_seq('{2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 9'h1FF, 1, 1'b1});
    held_seq('{2'b10, 2'd1, 2'd1, 2'd1, 2'd2, 9'h000, LAT_EX, 1'b0});

    // asynchronous reset in the middle of a LOAD burst
    ab = '{2'b00, 2'd3, 2'd0, 2'd0, 2'd0, 9'h080, 19, 1'b0};
    @(negedge clk);
    drive(ab);
    @(posedge clk);
    model_issue(ab, 1'b0);
    #1 cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_outputs", any_out, 0);
    aq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_state();
    run_cmd(ab);

    chk("leftover_mem_expect", aq.size(), 0);
    chk("leftover_scoreboard", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
